// File: rtl/hack_scan_buffer.sv
// hack_scan_buffer
//   Word-packed monochrome Hack screen buffer placed at (X_OFFSET, Y_OFFSET)
//   inside a larger VGA raster. The VGA beam position is turned into one
//   pixel per clock through a fixed two-cycle registered read pipeline.
//
//   Optional feature macro: HACK_SCAN_BUFFER_DOUBLE_BUFFER_EN
//     defined   : two banks, CPU writes the back bank, display reads the
//                 front bank, swaps are deferred to the frame start (0,0).
//     undefined : single bank shared by reads and writes, swap_req ignored,
//                 front_bank tied to 0.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   write_address  : CPU word address (low ADDR_W bits used, range-checked)
//   data_in, load  : CPU write word and write enable
//   vga_h, vga_v   : current VGA column / line
//   vga_de         : display enable from the timing generator
//   swap_req       : one-cycle swap request pulse
//   pixel_out      : pixel for the coordinates presented 2 cycles earlier
//   pixel_valid    : vga_de delayed by 2 cycles
//   front_bank     : bank being displayed

module hack_scan_buffer #(
  parameter int H_RES    = 512,
  parameter int V_RES    = 256,
  parameter int X_OFFSET = 144,
  parameter int Y_OFFSET = 112,
  parameter int WORD_W   = 16,
  parameter int ADDR_W   = 13,
  parameter int CNT_W    = 11,
  parameter bit BORDER   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       write_address,
  input  logic [WORD_W-1:0] data_in,
  input  logic              load,
  input  logic [CNT_W-1:0]  vga_h,
  input  logic [CNT_W-1:0]  vga_v,
  input  logic              vga_de,
  input  logic              swap_req,
  output logic              pixel_out,
  output logic              pixel_valid,
  output logic              front_bank
);

  localparam int DEPTH  = H_RES * V_RES / WORD_W;
  localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int STAGES = 2;

  // Registered address-stage side information travelling with the RAM read.
  typedef struct packed {
    logic             win;
    logic [BIT_W-1:0] bsel;
  } s1_t;

  // ---------------------------------------------------------------------
  // Address stage (combinational, cycle N)
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]  rel_x, rel_y;
  logic [31:0]       h32, v32, pix_idx;
  logic              in_win;
  logic [ADDR_W-1:0] rd_addr;
  logic [BIT_W-1:0]  bit_sel;

  assign rel_x = vga_h - CNT_W'(X_OFFSET);
  assign rel_y = vga_v - CNT_W'(Y_OFFSET);
  assign h32   = 32'(vga_h);
  assign v32   = 32'(vga_v);

  always_comb begin
    in_win  = 1'b0;
    pix_idx = '0;
    rd_addr = '0;
    bit_sel = '0;
    // Bounds compared at 32 bits so X_OFFSET+H_RES may exceed the counter range.
    in_win  = vga_de
              && (h32 >= 32'(X_OFFSET)) && (h32 < 32'(X_OFFSET + H_RES))
              && (v32 >= 32'(Y_OFFSET)) && (v32 < 32'(Y_OFFSET + V_RES));
    pix_idx = 32'(rel_y) * 32'(H_RES) + 32'(rel_x);
    bit_sel = BIT_W'(32'(rel_x) % 32'(WORD_W));
    // Outside the window the RAM still gets a defined, harmless address.
    if (in_win)
      rd_addr = ADDR_W'(pix_idx / 32'(WORD_W));
  end

  // ---------------------------------------------------------------------
  // Write qualification: the full 16-bit address is range-checked so
  // aliasing addresses beyond the screen never land in the RAM.
  // ---------------------------------------------------------------------
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  assign wr_en   = load && (32'(write_address) < 32'(DEPTH));
  assign wr_addr = write_address[ADDR_W-1:0];

  // ---------------------------------------------------------------------
  // Bank control and RAM
  // ---------------------------------------------------------------------
  logic [WORD_W-1:0] rd_word;

`ifdef HACK_SCAN_BUFFER_DOUBLE_BUFFER_EN
  logic front_q;
  logic swap_pending;
  logic frame_start;

  assign frame_start = (vga_h == '0) && (vga_v == '0);

  // A request arriving on the frame-start cycle is serviced immediately;
  // otherwise it is held, and extra requests before servicing collapse.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_q      <= 1'b0;
      swap_pending <= 1'b0;
    end else if (frame_start && (swap_pending || swap_req)) begin
      front_q      <= ~front_q;
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end

  assign front_bank = front_q;

  logic [WORD_W-1:0] mem [2][DEPTH];

  // Read and write in one process with non-blocking assignments: a read of
  // the address being written returns the pre-write word. The read bank is
  // latched with the address, so in-flight pixels finish from the old bank.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[~front_q][wr_addr] <= data_in;
    rd_word <= mem[front_q][rd_addr];
  end
`else
  logic unused_swap;
  assign unused_swap = swap_req;
  assign front_bank  = 1'b0;

  logic [WORD_W-1:0] mem [DEPTH];

  // Read-old-data on a same-cycle collision (see double-buffer branch).
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= data_in;
    rd_word <= mem[rd_addr];
  end
`endif

  // ---------------------------------------------------------------------
  // Pipeline: stage 1 holds window/bit-select alongside the RAM read,
  // stage 2 registers the selected pixel.
  // ---------------------------------------------------------------------
  s1_t               s1;
  logic [STAGES:1]   vld_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= '0;
      vld_pipe <= '0;
    end else begin
      s1.win   <= in_win;
      s1.bsel  <= bit_sel;
      vld_pipe <= {vld_pipe[STAGES-1:1], vga_de};
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      pixel_out <= BORDER;
    else
      pixel_out <= s1.win ? rd_word[s1.bsel] : BORDER;
  end

  assign pixel_valid = vld_pipe[STAGES];

endmodule
